enemy_wave_control: RTL and testbench
=====================================

Name: enemy_wave_control

Overview:
Multi-slot successor to the single-enemy controller. Manages N_ENEMIES independent enemy slots on the vector display. Each slot spawns on a shared spawn pulse and steps toward a parametrised base target on each speed pulse. A slot is freed when it is hit by the player or when it reaches the base. Sits between the timer cluster (spawn/speed pulses) and the vector drawing mux; the mux reads slot coordinates through an indexed read port.

Parameters:
OUT_WIDTH, 8, coordinate width (equals DAC_WIDTH).
N_ENEMIES, 4, number of enemy slots (1..16).
STEP, 1, coordinate increment per speed pulse, per axis (1..2^OUT_WIDTH-1).
TARGET_X, X_BASE1, base x coordinate (vector_pkg).
TARGET_Y, Y_BASE1, base y coordinate (vector_pkg).
KILL_CNT_W, 8, width of the saturating kill counter.

Ports:
clk  in  1  system clock (100 MHz).
rst  in  1  asynchronous, active-low reset.
spawn_pulse  in  1  one-cycle request to spawn one enemy.
spawn_y  in  OUT_WIDTH  start y of the new enemy, sampled with spawn_pulse.
speed_pulse  in  1  one-cycle movement tick.
hit  in  N_ENEMIES  one-cycle per-slot kill request.
rd_idx  in  $clog2(N_ENEMIES) (min 1)  slot index for the read port.
rd_x  out  OUT_WIDTH  x of slot rd_idx (combinational read of registered state).
rd_y  out  OUT_WIDTH  y of slot rd_idx.
rd_alive  out  1  slot rd_idx is FLYING.
alive  out  N_ENEMIES  per-slot FLYING mask.
spawn  out  1  registered pulse: a spawn was accepted.
spawn_drop  out  1  registered pulse: a spawn was rejected because all slots were busy.
base_hit  out  1  registered pulse: at least one enemy reached the base.
kills  out  KILL_CNT_W  saturating count of accepted hits.

Behaviour:
- Reset (rst=0, async): all slots IDLE, x=y=0, alive=0, spawn=spawn_drop=base_hit=0, kills=0. Reset mid-flight discards all enemies immediately.
- Slot states (enemy_state_t): IDLE, FLYING.
- Spawn: on spawn_pulse, the lowest-index slot that is IDLE at the start of the cycle is chosen. It becomes FLYING with x=0, y=spawn_y. spawn=1 next cycle. If no slot is IDLE, spawn_drop=1 next cycle and state is unchanged. At most one spawn per pulse.
- A slot freed in cycle T (by kill or arrival) is not spawnable until T+1.
- Move: on speed_pulse, each FLYING slot updates each axis independently.
  - If coord < target: coord += min(STEP, target-coord).
  - If coord > target: coord -= min(STEP, coord-target).
  - The arithmetic never overshoots or wraps.
- Arrival: on speed_pulse, a FLYING slot whose x==TARGET_X and y==TARGET_Y before the update goes IDLE. base_hit=1 next cycle, with one pulse even if several slots arrive together. Arrival is therefore observed one speed tick after the coordinates match.
- Kill: hit[i]=1 while slot i is FLYING sets slot i IDLE next cycle; its coordinates are held, not cleared. kills increments by popcount of accepted hits and saturates at all-ones. hit on an IDLE slot is ignored.
- Priority per slot when events coincide: kill > arrival > move. A hit in the same cycle as an arrival suppresses that slot's base_hit contribution.
- Spawn vs kill in the same cycle: the killed slot is not re-spawned that cycle (per the free-at-T+1 rule).
- spawn_pulse and speed_pulse in the same cycle: the newly spawned slot does not move that cycle; existing slots move.
- Latency: every state change is visible on outputs 1 cycle after the input pulse.

Decomposition:
- vector_pkg: already holds DAC_WIDTH, X_BASE1, Y_BASE1. Add enemy_state_t (IDLE, FLYING).
- One sub-module, enemy_slot: holds one slot's state, x and y. Inputs: spawn_en, spawn_y, speed_pulse, hit. Outputs: pos, alive, arrived.
- The top instantiates N_ENEMIES enemy_slot via generate. The top also owns the priority encoder (free slot), the read mux, the pulse registers and the kill counter.

Test Plan:
All scenarios use OUT_WIDTH=8, N_ENEMIES=4, STEP=1, TARGET=(200,100).
1. Reset, then spawn_pulse with spawn_y=40 -> next cycle spawn=1, alive=4'b0001, slot0=(0,40). After 60 speed pulses slot0=(60,100). After 200 pulses (200,100). The 201st pulse gives base_hit=1 and alive=0.
2. Five spawn_pulses with no hits -> alive=4'b1111 after the fourth; the fifth gives spawn_drop=1 with state unchanged.
3. Slots 0..2 FLYING; pulse hit=4'b0110 together with spawn_pulse -> alive=4'b0001 and kills=2. The spawn goes to slot 3 (alive=4'b1001), not to slot 1.
4. Slot0 at (200,100): hit[0] on the same cycle as speed_pulse -> base_hit=0, kills+1, alive[0]=0.
5. STEP=3, spawn_y=250 -> y sequence 247,244,..., ending exactly at 100 with no overshoot. x ends exactly at 200: 66 full steps reach 198, then one clamped step of 2.
6. Drive rst low mid-flight asynchronously (between clk edges) -> alive=0 and kills=0 immediately, without a clock edge.
7. KILL_CNT_W=2 -> kills saturates at 3 after 4+ accepted hits.

Source files
------------

// File: rtl/vector_pkg.sv
// Shared constants for the vector display datapath and enemy slot state.
//   DAC_WIDTH - coordinate width driven to the vector DACs
//   X_BASE1   - x coordinate of the player base
//   Y_BASE1   - y coordinate of the player base
//   enemy_state_t - per-slot lifecycle state
package vector_pkg;

   localparam int unsigned DAC_WIDTH = 8;
   localparam int unsigned X_BASE1   = 200;
   localparam int unsigned Y_BASE1   = 100;

   typedef enum logic {
      IDLE   = 1'b0,
      FLYING = 1'b1
   } enemy_state_t;

endpackage

// File: rtl/enemy_slot.sv
// One enemy slot: lifecycle state plus x/y position.
//   clk, rst      - clock, asynchronous active-low reset
//   spawn_en      - start flying from (0, spawn_y); only asserted while IDLE
//   spawn_y       - start y for a spawn
//   speed_pulse   - movement tick
//   hit           - kill request, ignored while IDLE
//   pos           - {x, y} of this slot
//   alive         - slot is FLYING
//   arrived       - combinational: this tick retires the slot at the base
module enemy_slot
   import vector_pkg::*;
#(
   parameter int unsigned         OUT_WIDTH = DAC_WIDTH,
   parameter int unsigned         STEP      = 1,
   parameter logic [OUT_WIDTH-1:0] TARGET_X = OUT_WIDTH'(X_BASE1),
   parameter logic [OUT_WIDTH-1:0] TARGET_Y = OUT_WIDTH'(Y_BASE1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   spawn_en,
   input  logic [OUT_WIDTH-1:0]   spawn_y,
   input  logic                   speed_pulse,
   input  logic                   hit,
   output logic [2*OUT_WIDTH-1:0] pos,
   output logic                   alive,
   output logic                   arrived
);

   localparam logic [OUT_WIDTH-1:0] STEP_C = OUT_WIDTH'(STEP);

   enemy_state_t         state_q;
   logic [OUT_WIDTH-1:0] x_q, y_q;
   logic                 at_target;

   // Moves cur toward tgt by at most STEP; the final step is clamped so the
   // coordinate lands exactly on the target instead of overshooting or wrapping.
   function automatic logic [OUT_WIDTH-1:0] step_toward(
      input logic [OUT_WIDTH-1:0] cur,
      input logic [OUT_WIDTH-1:0] tgt
   );
      logic [OUT_WIDTH-1:0] gap;
      logic [OUT_WIDTH-1:0] res;
      gap = '0;
      res = cur;
      if (cur < tgt) begin
         gap = tgt - cur;
         res = (gap > STEP_C) ? cur + STEP_C : tgt;
      end else if (cur > tgt) begin
         gap = cur - tgt;
         res = (gap > STEP_C) ? cur - STEP_C : tgt;
      end
      return res;
   endfunction

   assign at_target = (x_q == TARGET_X) && (y_q == TARGET_Y);
   assign alive     = (state_q == FLYING);
   // A kill in the same cycle takes precedence and suppresses the arrival.
   assign arrived   = alive && speed_pulse && at_target && !hit;
   assign pos       = {x_q, y_q};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (spawn_en) begin
                  state_q <= FLYING;
                  x_q     <= '0;
                  y_q     <= spawn_y;
               end
            end
            FLYING: begin
               if (hit) begin
                  state_q <= IDLE;           // coordinates held on kill
               end else if (speed_pulse) begin
                  if (at_target) begin
                     state_q <= IDLE;
                  end else begin
                     x_q <= step_toward(x_q, TARGET_X);
                     y_q <= step_toward(y_q, TARGET_Y);
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/enemy_wave_control.sv
// Multi-slot enemy controller between the timer cluster and the vector mux.
//   clk, rst          - clock, asynchronous active-low reset
//   spawn_pulse/_y    - request one spawn at (0, spawn_y)
//   speed_pulse       - movement tick for every FLYING slot
//   hit[N]            - per-slot kill request
//   rd_idx            - read port index; rd_x/rd_y/rd_alive reflect that slot
//   alive[N]          - FLYING mask
//   spawn, spawn_drop - registered accept / reject pulse for a spawn request
//   base_hit          - registered pulse: one or more enemies reached the base
//   kills             - saturating count of accepted hits
module enemy_wave_control
   import vector_pkg::*;
#(
   parameter int unsigned OUT_WIDTH  = DAC_WIDTH,
   parameter int unsigned N_ENEMIES  = 4,
   parameter int unsigned STEP       = 1,
   parameter int unsigned TARGET_X   = X_BASE1,
   parameter int unsigned TARGET_Y   = Y_BASE1,
   parameter int unsigned KILL_CNT_W = 8,
   localparam int unsigned IDX_W     = (N_ENEMIES > 1) ? $clog2(N_ENEMIES) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  spawn_pulse,
   input  logic [OUT_WIDTH-1:0]  spawn_y,
   input  logic                  speed_pulse,
   input  logic [N_ENEMIES-1:0]  hit,
   input  logic [IDX_W-1:0]      rd_idx,
   output logic [OUT_WIDTH-1:0]  rd_x,
   output logic [OUT_WIDTH-1:0]  rd_y,
   output logic                  rd_alive,
   output logic [N_ENEMIES-1:0]  alive,
   output logic                  spawn,
   output logic                  spawn_drop,
   output logic                  base_hit,
   output logic [KILL_CNT_W-1:0] kills
);

   localparam int unsigned SUM_W = KILL_CNT_W + 6;

   logic [N_ENEMIES-1:0] grant_d;
   logic                 any_free_d;
   logic [N_ENEMIES-1:0] arrived;
   logic [OUT_WIDTH-1:0] x_arr [N_ENEMIES];
   logic [OUT_WIDTH-1:0] y_arr [N_ENEMIES];
   logic [SUM_W-1:0]     kill_sum_d;
   logic [KILL_CNT_W-1:0] kills_d;

   logic                  spawn_q, drop_q, base_hit_q;
   logic [KILL_CNT_W-1:0] kills_q;

   // Lowest-index slot that is IDLE at the start of the cycle. A slot killed
   // or arriving this cycle still reads alive here, so it is not reused until
   // the next cycle.
   always_comb begin
      grant_d    = '0;
      any_free_d = 1'b0;
      for (int unsigned i = 0; i < N_ENEMIES; i++) begin
         if (!alive[i] && !any_free_d) begin
            grant_d[i] = 1'b1;
            any_free_d = 1'b1;
         end
      end
   end

   for (genvar g = 0; g < N_ENEMIES; g++) begin : g_slot
      logic [2*OUT_WIDTH-1:0] pos;
      enemy_slot #(
         .OUT_WIDTH (OUT_WIDTH),
         .STEP      (STEP),
         .TARGET_X  (OUT_WIDTH'(TARGET_X)),
         .TARGET_Y  (OUT_WIDTH'(TARGET_Y))
      ) u_slot (
         .clk         (clk),
         .rst         (rst),
         .spawn_en    (spawn_pulse && grant_d[g]),
         .spawn_y     (spawn_y),
         .speed_pulse (speed_pulse),
         .hit         (hit[g]),
         .pos         (pos),
         .alive       (alive[g]),
         .arrived     (arrived[g])
      );
      assign x_arr[g] = pos[2*OUT_WIDTH-1:OUT_WIDTH];
      assign y_arr[g] = pos[OUT_WIDTH-1:0];
   end

   always_comb begin
      kill_sum_d = SUM_W'(kills_q);
      for (int unsigned i = 0; i < N_ENEMIES; i++) begin
         kill_sum_d = kill_sum_d + SUM_W'(hit[i] & alive[i]);
      end
      kills_d = (kill_sum_d > SUM_W'({KILL_CNT_W{1'b1}})) ? '1 : kill_sum_d[KILL_CNT_W-1:0];
   end

   always_comb begin
      rd_x     = '0;
      rd_y     = '0;
      rd_alive = 1'b0;
      for (int unsigned i = 0; i < N_ENEMIES; i++) begin
         if (rd_idx == IDX_W'(i)) begin
            rd_x     = x_arr[i];
            rd_y     = y_arr[i];
            rd_alive = alive[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         spawn_q    <= 1'b0;
         drop_q     <= 1'b0;
         base_hit_q <= 1'b0;
         kills_q    <= '0;
      end else begin
         spawn_q    <= spawn_pulse && any_free_d;
         drop_q     <= spawn_pulse && !any_free_d;
         base_hit_q <= |arrived;
         kills_q    <= kills_d;
      end
   end

   assign spawn      = spawn_q;
   assign spawn_drop = drop_q;
   assign base_hit   = base_hit_q;
   assign kills      = kills_q;

endmodule

// File: tb/tb_enemy_wave_control.sv
module tb_enemy_wave_control;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       spawn_pulse = 1'b0;
   logic [7:0] spawn_y = '0;
   logic       speed_pulse = 1'b0;
   logic [3:0] hit = '0;
   logic [1:0] rd_idx = '0;

   logic [7:0] a_x, a_y, b_x, b_y, c_x, c_y;
   logic       a_ra, b_ra, c_ra;
   logic [3:0] a_alive, b_alive, c_alive;
   logic       a_sp, a_dr, a_bh, b_sp, b_dr, b_bh, c_sp, c_dr, c_bh;
   logic [7:0] a_kills, b_kills;
   logic [1:0] c_kills;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   enemy_wave_control #(.OUT_WIDTH(8), .N_ENEMIES(4), .STEP(1), .TARGET_X(200),
                        .TARGET_Y(100), .KILL_CNT_W(8)) dut_a (
      .clk(clk), .rst(rst), .spawn_pulse(spawn_pulse), .spawn_y(spawn_y),
      .speed_pulse(speed_pulse), .hit(hit), .rd_idx(rd_idx), .rd_x(a_x), .rd_y(a_y),
      .rd_alive(a_ra), .alive(a_alive), .spawn(a_sp), .spawn_drop(a_dr),
      .base_hit(a_bh), .kills(a_kills));

   enemy_wave_control #(.OUT_WIDTH(8), .N_ENEMIES(4), .STEP(3), .TARGET_X(200),
                        .TARGET_Y(100), .KILL_CNT_W(8)) dut_b (
      .clk(clk), .rst(rst), .spawn_pulse(spawn_pulse), .spawn_y(spawn_y),
      .speed_pulse(speed_pulse), .hit(hit), .rd_idx(rd_idx), .rd_x(b_x), .rd_y(b_y),
      .rd_alive(b_ra), .alive(b_alive), .spawn(b_sp), .spawn_drop(b_dr),
      .base_hit(b_bh), .kills(b_kills));

   enemy_wave_control #(.OUT_WIDTH(8), .N_ENEMIES(4), .STEP(1), .TARGET_X(200),
                        .TARGET_Y(100), .KILL_CNT_W(2)) dut_c (
      .clk(clk), .rst(rst), .spawn_pulse(spawn_pulse), .spawn_y(spawn_y),
      .speed_pulse(speed_pulse), .hit(hit), .rd_idx(rd_idx), .rd_x(c_x), .rd_y(c_y),
      .rd_alive(c_ra), .alive(c_alive), .spawn(c_sp), .spawn_drop(c_dr),
      .base_hit(c_bh), .kills(c_kills));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // Inputs change 1 time unit after the active edge; outputs sampled there.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      spawn_pulse = 1'b0;
      speed_pulse = 1'b0;
      hit = '0;
      rd_idx = '0;
      repeat (2) tick();
      rst = 1'b1;
   endtask

   task automatic do_spawn(input logic [7:0] y);
      spawn_y = y;
      spawn_pulse = 1'b1;
      tick();
      spawn_pulse = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      #1;
      do_reset();
      chk("rst_alive", a_alive, 0);
      chk("rst_kills", a_kills, 0);
      chk("rst_spawn", a_sp, 0);
      chk("rst_x", a_x, 0);

      // 1: single enemy flies to the base
      do_spawn(8'd40);
      chk("s1_spawn", a_sp, 1);
      chk("s1_alive", a_alive, 4'b0001);
      chk("s1_x0", a_x, 0);
      chk("s1_y0", a_y, 40);
      speed_pulse = 1'b1;
      repeat (60) tick();
      chk("s1_x60", a_x, 60);
      chk("s1_y60", a_y, 100);
      repeat (140) tick();
      chk("s1_x200", a_x, 200);
      chk("s1_y200", a_y, 100);
      chk("s1_alive200", a_alive, 4'b0001);
      chk("s1_bh200", a_bh, 0);
      tick();
      speed_pulse = 1'b0;
      chk("s1_bh201", a_bh, 1);
      chk("s1_alive201", a_alive, 0);
      tick();
      chk("s1_bh_pulse", a_bh, 0);

      // 2: fill all slots, fifth spawn is dropped
      do_reset();
      do_spawn(8'd10);
      do_spawn(8'd20);
      do_spawn(8'd30);
      do_spawn(8'd40);
      chk("s2_alive4", a_alive, 4'b1111);
      chk("s2_drop4", a_dr, 0);
      do_spawn(8'd99);
      chk("s2_drop5", a_dr, 1);
      chk("s2_spawn5", a_sp, 0);
      chk("s2_alive5", a_alive, 4'b1111);
      rd_idx = 2'd3;
      #1;
      chk("s2_y3", a_y, 40);
      chk("s2_ra3", a_ra, 1);

      // 3: kill slots 1,2 while spawning; spawn goes to slot 3
      do_reset();
      do_spawn(8'd10);
      do_spawn(8'd20);
      do_spawn(8'd30);
      hit = 4'b0110;
      do_spawn(8'd77);
      hit = '0;
      chk("s3_alive", a_alive, 4'b1001);
      chk("s3_kills", a_kills, 2);
      chk("s3_spawn", a_sp, 1);
      rd_idx = 2'd3;
      #1;
      chk("s3_y3", a_y, 77);
      rd_idx = 2'd1;
      #1;
      chk("s3_ra1", a_ra, 0);
      chk("s3_y1_held", a_y, 20);
      hit = 4'b0010;
      tick();
      hit = '0;
      chk("s3_idle_hit", a_kills, 2);

      // 4: hit coincides with arrival
      do_reset();
      do_spawn(8'd100);
      speed_pulse = 1'b1;
      repeat (200) tick();
      chk("s4_x", a_x, 200);
      hit = 4'b0001;
      tick();
      hit = '0;
      speed_pulse = 1'b0;
      chk("s4_bh", a_bh, 0);
      chk("s4_kills", a_kills, 1);
      chk("s4_alive", a_alive, 0);
      chk("s4_x_held", a_x, 200);
      chk("s4_y_held", a_y, 100);

      // 5: STEP=3 clamps on the last step of each axis
      do_reset();
      do_spawn(8'd250);
      speed_pulse = 1'b1;
      tick();
      chk("s5_x1", b_x, 3);
      chk("s5_y1", b_y, 247);
      repeat (49) tick();
      chk("s5_x50", b_x, 150);
      chk("s5_y50", b_y, 100);
      repeat (16) tick();
      chk("s5_x66", b_x, 198);
      chk("s5_y66", b_y, 100);
      tick();
      chk("s5_x67", b_x, 200);
      chk("s5_alive67", b_alive, 4'b0001);
      chk("s5_bh67", b_bh, 0);
      tick();
      speed_pulse = 1'b0;
      chk("s5_bh68", b_bh, 1);
      chk("s5_alive68", b_alive, 0);

      // 6: asynchronous reset mid-flight
      do_reset();
      do_spawn(8'd5);
      speed_pulse = 1'b1;
      repeat (3) tick();
      speed_pulse = 1'b0;
      hit = 4'b0001;
      tick();
      hit = '0;
      do_spawn(8'd6);
      chk("s6_pre_kills", a_kills, 1);
      chk("s6_pre_alive", a_alive, 4'b0001);
      #2;
      rst = 1'b0;
      #1;
      chk("s6_async_alive", a_alive, 0);
      chk("s6_async_kills", a_kills, 0);
      tick();
      rst = 1'b1;

      // 7: 2-bit kill counter saturates
      do_reset();
      do_spawn(8'd1);
      do_spawn(8'd2);
      hit = 4'b0011;
      tick();
      hit = '0;
      chk("s7_kills2", c_kills, 2);
      do_spawn(8'd3);
      do_spawn(8'd4);
      hit = 4'b0011;
      tick();
      hit = '0;
      chk("s7_kills_sat", c_kills, 3);
      do_spawn(8'd5);
      hit = 4'b0001;
      tick();
      hit = '0;
      chk("s7_kills_hold", c_kills, 3);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
